// File: rtl/lightgun_pkg.sv
// Shared types and widths for the two-player lightgun sensor scheduler.
package lightgun_pkg;

    localparam int unsigned HC_W = 10;
    localparam int unsigned VC_W = 9;

    typedef logic player_t;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        SENSE,
        DONE,
        RLD
    } state_e;

    function automatic logic [1:0] player_mask(input player_t p);
        return p ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/lightgun_trig_arb.sv
// Trigger edge detect, pending flags and round-robin grant for two players.
module lightgun_trig_arb
    import lightgun_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [1:0] trig,
    input  logic       grant_en_c,
    input  logic       busy,
    input  player_t    cur_g,
    output logic       gnt_c,
    output player_t    gnt_idx_c
);

    logic [1:0] trig_prev_q, trig_prev_d;
    logic [1:0] pend_q, pend_d;
    logic       rr_ptr_q, rr_ptr_d;
    logic [1:0] rise, drop, clr;

    always_comb begin
        rise        = trig & ~trig_prev_q;
        // A new pull from the player already being serviced is ignored.
        drop        = busy ? player_mask(cur_g) : 2'b00;
        gnt_c       = grant_en_c && (pend_q != 2'b00);
        gnt_idx_c   = (pend_q == 2'b11) ? rr_ptr_q : pend_q[1];
        clr         = gnt_c ? player_mask(gnt_idx_c) : 2'b00;
        pend_d      = (pend_q & ~clr) | (rise & ~drop);
        rr_ptr_d    = gnt_c ? ~gnt_idx_c : rr_ptr_q;
        trig_prev_d = trig;
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            trig_prev_q <= 2'b00;
            pend_q      <= 2'b00;
            rr_ptr_q    <= 1'b0;
        end else begin
            trig_prev_q <= trig_prev_d;
            pend_q      <= pend_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/lightgun_sensor_sched.sv
// Per-frame scheduler: grants one lightgun per frame, raises SENSOR inside its aim window or RELOAD when offscreen.
module lightgun_sensor_sched
    import lightgun_pkg::*;
#(
    parameter int unsigned SENSOR_PIX    = 16,
    parameter int unsigned SENSOR_LINES  = 2,
    parameter int unsigned RELOAD_FRAMES = 5
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            CE_PIX,
    input  logic            VDE,
    input  logic [HC_W-1:0] H_COUNT,
    input  logic [VC_W-1:0] V_COUNT,
    input  logic [1:0]      TRIG,
    input  logic [HC_W-1:0] X0,
    input  logic [HC_W-1:0] X1,
    input  logic [VC_W-1:0] Y0,
    input  logic [VC_W-1:0] Y1,
    input  logic [1:0]      OFFSCREEN,
    output logic [1:0]      SENSOR,
    output logic [1:0]      TRIG_OUT,
    output logic [1:0]      RELOAD,
    output logic            BUSY
);

    state_e          state_q, state_d;
    player_t         g_q, g_d;
    logic [HC_W-1:0] x_q, x_d;
    logic [VC_W-1:0] y_q, y_d;
    logic [3:0]      rld_cnt_q, rld_cnt_d;
    logic            vde_prev_q, vde_prev_d;
    logic [1:0]      sensor_q, sensor_d;
    logic [1:0]      trig_out_q, trig_out_d;
    logic [1:0]      reload_q, reload_d;
    logic            busy_q, busy_d;

    logic            fs_c, vfall_c, in_win_c, below_c, grant_en_c, start_c;
    logic            gnt_c;
    player_t         gnt_idx_c;
    logic [HC_W:0]   xe_c;
    logic [VC_W:0]   ye_c;
    logic [HC_W-1:0] sel_x_c;
    logic [VC_W-1:0] sel_y_c;
    logic            sel_off_c;

    lightgun_trig_arb u_arb (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .trig       (TRIG),
        .grant_en_c (grant_en_c),
        .busy       (busy_q),
        .cur_g      (g_q),
        .gnt_c      (gnt_c),
        .gnt_idx_c  (gnt_idx_c)
    );

    // Frame edges and window compare; bounds are one bit wider so they never wrap.
    always_comb begin
        fs_c       = CE_PIX && VDE && !vde_prev_q;
        vfall_c    = CE_PIX && !VDE && vde_prev_q;
        vde_prev_d = CE_PIX ? VDE : vde_prev_q;
        xe_c       = {1'b0, x_q} + (HC_W+1)'(SENSOR_PIX - 1);
        ye_c       = {1'b0, y_q} + (VC_W+1)'(SENSOR_LINES - 1);
        in_win_c   = VDE && (H_COUNT >= x_q) && ({1'b0, H_COUNT} <= xe_c)
                         && (V_COUNT >= y_q) && ({1'b0, V_COUNT} <= ye_c);
        below_c    = {1'b0, V_COUNT} > ye_c;
        grant_en_c = fs_c && ((state_q == IDLE) || (state_q == DONE));
        sel_x_c    = gnt_idx_c ? X1 : X0;
        sel_y_c    = gnt_idx_c ? Y1 : Y0;
        sel_off_c  = gnt_idx_c ? OFFSCREEN[1] : OFFSCREEN[0];
    end

    always_comb begin
        state_d   = state_q;
        g_d       = g_q;
        x_d       = x_q;
        y_d       = y_q;
        rld_cnt_d = rld_cnt_q;
        start_c   = 1'b0;

        case (state_q)
            IDLE:  if (gnt_c) start_c = 1'b1;
            ARMED: begin
                if (vfall_c)                 state_d = DONE;
                else if (CE_PIX && in_win_c) state_d = SENSE;
            end
            SENSE: if (vfall_c || (CE_PIX && below_c)) state_d = DONE;
            DONE: begin
                if (fs_c) begin
                    if (gnt_c) start_c = 1'b1;
                    else       state_d = IDLE;
                end
            end
            RLD: begin
                if (fs_c) begin
                    if (rld_cnt_q <= 4'd1) begin
                        state_d   = IDLE;
                        rld_cnt_d = 4'd0;
                    end else begin
                        rld_cnt_d = rld_cnt_q - 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Aim and offscreen are captured once at grant and held for the frame.
        if (start_c) begin
            g_d = gnt_idx_c;
            x_d = sel_x_c;
            y_d = sel_y_c;
            if (sel_off_c) begin
                state_d   = RLD;
                rld_cnt_d = 4'(RELOAD_FRAMES);
            end else begin
                state_d   = ARMED;
            end
        end

        sensor_d = sensor_q;
        if (CE_PIX) begin
            sensor_d = (((state_q == ARMED) || (state_q == SENSE)) && in_win_c)
                       ? player_mask(g_q) : 2'b00;
        end
        trig_out_d = (state_d != IDLE) ? player_mask(g_d) : 2'b00;
        reload_d   = (state_d == RLD)  ? player_mask(g_d) : 2'b00;
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q    <= IDLE;
            g_q        <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            rld_cnt_q  <= 4'd0;
            vde_prev_q <= 1'b0;
            sensor_q   <= 2'b00;
            trig_out_q <= 2'b00;
            reload_q   <= 2'b00;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            g_q        <= g_d;
            x_q        <= x_d;
            y_q        <= y_d;
            rld_cnt_q  <= rld_cnt_d;
            vde_prev_q <= vde_prev_d;
            sensor_q   <= sensor_d;
            trig_out_q <= trig_out_d;
            reload_q   <= reload_d;
            busy_q     <= busy_d;
        end
    end

    assign SENSOR   = sensor_q;
    assign TRIG_OUT = trig_out_q;
    assign RELOAD   = reload_q;
    assign BUSY     = busy_q;

endmodule

// File: tb/tb_lightgun_sensor_sched.sv
// Frame-level directed bench for lightgun_sensor_sched: per-frame vector table plus corner sequences.
module tb_lightgun_sensor_sched;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       CE_PIX = 1'b1;
    logic       VDE = 1'b0;
    logic [9:0] H_COUNT = '0;
    logic [8:0] V_COUNT = '0;
    logic [1:0] TRIG = 2'b00;
    logic [9:0] X0 = 10'd100;
    logic [9:0] X1 = 10'd110;
    logic [8:0] Y0 = 9'd50;
    logic [8:0] Y1 = 9'd46;
    logic [1:0] OFFSCREEN = 2'b00;
    logic [1:0] SENSOR, TRIG_OUT, RELOAD;
    logic       BUSY;

    lightgun_sensor_sched dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .CE_PIX    (CE_PIX),
        .VDE       (VDE),
        .H_COUNT   (H_COUNT),
        .V_COUNT   (V_COUNT),
        .TRIG      (TRIG),
        .X0        (X0),
        .X1        (X1),
        .Y0        (Y0),
        .Y1        (Y1),
        .OFFSCREEN (OFFSCREEN),
        .SENSOR    (SENSOR),
        .TRIG_OUT  (TRIG_OUT),
        .RELOAD    (RELOAD),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0] trig;
        logic [1:0] off;
        logic [1:0] exp_to;
        logic [1:0] exp_rl;
        logic       exp_busy;
        int         exp_c0;
        int         exp_c1;
    } vec_t;

    vec_t vecs[15];

    int n_total = 0;
    int n_pass  = 0;
    int h_lo = 90, h_n = 40, v_lo = 45, v_n = 10;
    int cnt0, cnt1, hmin0, hmax0;
    logic [1:0] cap_to, cap_rl;
    logic       cap_busy;

    task automatic chk(input string name, input int idx, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s [%0d]: got %0d, expected %0d", name, idx, act, exp);
    endtask

    task automatic clr_mon();
        cnt0 = 0; cnt1 = 0; hmin0 = 99999; hmax0 = -1;
    endtask

    // Drive one pixel; outputs seen 1 ns after the edge belong to that pixel.
    task automatic pix(input logic vde, input int h, input int v);
        VDE = vde; H_COUNT = 10'(h); V_COUNT = 9'(v);
        @(posedge CLK); #1;
        if (SENSOR[0]) begin
            cnt0++;
            if (h < hmin0) hmin0 = h;
            if (h > hmax0) hmax0 = h;
        end
        if (SENSOR[1]) cnt1++;
    endtask

    task automatic blank(input int n);
        for (int i = 0; i < n; i++) pix(1'b0, 0, v_lo + v_n);
    endtask

    task automatic pulse(input logic [1:0] t);
        TRIG = t; blank(1);
        TRIG = 2'b00; blank(1);
    endtask

    task automatic frame();
        clr_mon();
        for (int v = v_lo; v < v_lo + v_n; v++)
            for (int i = 0; i < h_n; i++) pix(1'b1, (h_lo + i) % 1024, v);
        cap_to = TRIG_OUT; cap_rl = RELOAD; cap_busy = BUSY;
        blank(4);
    endtask

    initial begin
        bit found;
        vecs[0]  = '{2'b11, 2'b00, 2'b01, 2'b00, 1'b1, 32, 0};
        vecs[1]  = '{2'b00, 2'b00, 2'b10, 2'b00, 1'b1, 0, 32};
        vecs[2]  = '{2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 0, 0};
        vecs[3]  = '{2'b11, 2'b00, 2'b01, 2'b00, 1'b1, 32, 0};
        vecs[4]  = '{2'b00, 2'b00, 2'b10, 2'b00, 1'b1, 0, 32};
        vecs[5]  = '{2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 0, 0};
        vecs[6]  = '{2'b01, 2'b00, 2'b01, 2'b00, 1'b1, 32, 0};
        vecs[7]  = '{2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 0, 0};
        vecs[8]  = '{2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 0, 0};
        vecs[9]  = '{2'b10, 2'b10, 2'b10, 2'b10, 1'b1, 0, 0};
        for (int k = 10; k < 14; k++) vecs[k] = '{2'b00, 2'b00, 2'b10, 2'b10, 1'b1, 0, 0};
        vecs[14] = '{2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 0, 0};

        // Reset held for 3 clocks.
        clr_mon();
        blank(3);
        chk("rst_sensor",   0, int'(SENSOR),   0);
        chk("rst_trig_out", 0, int'(TRIG_OUT), 0);
        chk("rst_reload",   0, int'(RELOAD),   0);
        chk("rst_busy",     0, int'(BUSY),     0);
        RESET_N = 1'b1;
        blank(2);

        // One frame per row: trigger in blanking, then check the serviced frame.
        for (int r = 0; r < 15; r++) begin
            OFFSCREEN = vecs[r].off;
            if (vecs[r].trig != 2'b00) pulse(vecs[r].trig);
            frame();
            chk("trig_out", r, int'(cap_to),   int'(vecs[r].exp_to));
            chk("reload",   r, int'(cap_rl),   int'(vecs[r].exp_rl));
            chk("busy",     r, int'(cap_busy), int'(vecs[r].exp_busy));
            chk("sens0_cnt", r, cnt0, vecs[r].exp_c0);
            chk("sens1_cnt", r, cnt1, vecs[r].exp_c1);
            if (vecs[r].exp_c0 == 32) begin
                chk("sens0_hmin", r, hmin0, 100);
                chk("sens0_hmax", r, hmax0, 115);
            end
        end
        OFFSCREEN = 2'b00;

        // Right-edge clipping: window 1015..1030 must stop at column 1023.
        X0 = 10'd1015; Y0 = 9'd20;
        h_lo = 1008; h_n = 24; v_lo = 19; v_n = 4;
        blank(2);
        pulse(2'b01);
        frame();
        chk("clip_cnt",  0, cnt0,  18);
        chk("clip_hmin", 0, hmin0, 1015);
        chk("clip_hmax", 0, hmax0, 1023);
        chk("clip_busy", 0, int'(cap_busy), 1);
        frame();
        chk("clip_idle", 0, int'(cap_busy), 0);

        // Window below the active lines: ARMED until VDE falls, then DONE.
        X0 = 10'd100; Y0 = 9'd510;
        h_lo = 90; h_n = 40; v_lo = 45; v_n = 10;
        blank(2);
        pulse(2'b01);
        frame();
        chk("low_sens0",    0, cnt0, 0);
        chk("low_trig_out", 0, int'(cap_to), 1);
        chk("low_busy_blk", 0, int'(BUSY), 1);
        chk("low_to_blk",   0, int'(TRIG_OUT), 1);
        frame();
        chk("low_idle", 0, int'(cap_busy), 0);
        chk("low_to_idle", 0, int'(cap_to), 0);

        // Reset while SENSOR is high, with a P1 trigger pending.
        Y0 = 9'd50;
        pulse(2'b01);
        clr_mon();
        found = 1'b0;
        for (int v = v_lo; v < v_lo + v_n && !found; v++)
            for (int i = 0; i < h_n && !found; i++) begin
                TRIG = (v == 46 && i == 0) ? 2'b10 : 2'b00;
                pix(1'b1, h_lo + i, v);
                if (SENSOR[0]) found = 1'b1;
            end
        TRIG = 2'b00;
        chk("mid_sense_seen", 0, int'(found), 1);
        RESET_N = 1'b0;
        pix(1'b1, 101, 50);
        chk("mid_rst_sensor",   0, int'(SENSOR),   0);
        chk("mid_rst_busy",     0, int'(BUSY),     0);
        chk("mid_rst_trig_out", 0, int'(TRIG_OUT), 0);
        RESET_N = 1'b1;
        blank(4);
        frame();
        chk("mid_rst_pend_busy", 0, int'(cap_busy), 0);
        chk("mid_rst_pend_to",   0, int'(cap_to),   0);
        chk("mid_rst_pend_sens", 0, cnt0 + cnt1,    0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
